imem_arbiter: RTL
=================

# imem_arbiter

Single-port access controller for the 16 KB instruction memory, sharing it between the CPU fetch stage and the program loader. Holds fetch off after reset until the loader signals boot completion, then arbitrates loader-priority with a bounded starvation guard for fetch. Drives a synchronous-read, byte-enabled SRAM macro (one-cycle read latency) and routes each read response back to the requester that issued it.

## Interface
- ADDR_W, 14, byte-address width of the memory (16 KB); word address = ADDR_W-2 bits
- STARVE_LIMIT, 4, max consecutive cycles fetch may be denied in RUN while requesting (≥1)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- boot_done_i  in  1  loader pulse: program load complete
- booted_o  out  1  1 when in RUN state
- fetch_req_i  in  1  fetch read request
- fetch_addr_i  in  32  fetch byte address
- fetch_gnt_o  out  1  fetch request accepted this cycle
- fetch_rvalid_o  out  1  fetch read data valid
- fetch_rdata_o  out  32  fetch read data
- fetch_err_o  out  1  fetch access error, qualified by fetch_rvalid_o
- load_req_i  in  1  loader request
- load_we_i  in  1  1 = write, 0 = read
- load_addr_i  in  32  loader byte address (bits [1:0] ignored)
- load_be_i  in  4  write byte enables
- load_wdata_i  in  32  write data
- load_gnt_o  out  1  loader request accepted this cycle
- load_rvalid_o  out  1  loader read data valid (reads only)
- load_rdata_o  out  32  loader read data
- load_err_o  out  1  loader access error, qualified by load_rvalid_o or 1-cycle pulse after errored write
- mem_en_o  out  1  SRAM access enable
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  ADDR_W-2  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after a read enable

## Operation
- States: BOOT (reset state), RUN. BOOT→RUN on boot_done_i=1 (registered; takes effect next cycle). RUN is sticky until reset. boot_done_i in RUN ignored.
- BOOT: fetch_gnt_o=0 always; load_gnt_o=load_req_i.
- RUN, one requester: granted same cycle. Both requesting: loader wins unless starve_cnt==STARVE_LIMIT, then fetch wins.
- starve_cnt (RUN only): +1 each cycle fetch_req_i=1 and fetch_gnt_o=0; cleared when fetch granted or fetch_req_i=0; saturates at STARVE_LIMIT. Held at 0 in BOOT.
- Grant is combinational (req→gnt same cycle); a request is accepted when req&&gnt. Requester holds req/addr/data stable until granted.
- Accepted access drives mem_en_o=1, mem_addr_o=addr[ADDR_W-1:2]; fetch: mem_we_o=0, mem_be_o=0; loader: mem_we_o=load_we_i, mem_be_o=load_be_i (0 for reads).
- Response owner register (none/fetch/load) captured on each accepted read; next cycle raises that requester's rvalid with rdata=mem_rdata_i. Non-owner rdata=0.
- Writes produce no rvalid. Back-to-back accesses every cycle supported; no idle bubble.

## Timing
- Reset values: state=BOOT, booted_o=0, starve_cnt=0, owner=none, all rvalid/err=0, rdata=0. Grants/mem_* combinational: 0 with no request.
- Read latency: exactly 1 cycle gnt→rvalid.
- Reset asserted mid-access: outstanding response dropped, no rvalid after reset release.
- boot_done_i and both requests same cycle in BOOT: loader granted, fetch not; fetch eligible next cycle.

## Configuration
- IMEM_ARB_ERR_EN defined: access with addr[31:ADDR_W]≠0, or fetch with fetch_addr_i[1:0]≠0, is granted normally but mem_en_o=0; fetch/load read returns rvalid next cycle with err=1, rdata=0; errored write drops and pulses load_err_o next cycle.
- Undefined: no checks; upper and low address bits truncated; fetch_err_o/load_err_o tied 0.

## Test plan
- Reset, fetch_req_i=1 held, no boot_done_i → fetch_gnt_o=0 for 20 cycles; loader write 0xDEADBEEF to 0x40 with be=0xF → mem_we_o=1, mem_addr_o=0x10.
- Pulse boot_done_i, fetch 0x40 → booted_o=1 next cycle; fetch_gnt_o same cycle as request; fetch_rvalid_o next cycle, rdata=0xDEADBEEF.
- RUN, both request continuously, STARVE_LIMIT=4 → loader granted 4 cycles, fetch 5th, pattern repeats; no rvalid misrouted.
- Loader read and fetch read on alternating cycles → each rvalid one cycle after own gnt, correct data, other rvalid low.
- rst_i asserted in cycle after read grant → no rvalid; state BOOT, booted_o=0.
- IMEM_ARB_ERR_EN, fetch 0x0000_4000 and 0x42 → mem_en_o=0, fetch_err_o=1 with rvalid, rdata=0; without macro, 0x4000 reads word 0.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if
//   Bundles the boot handshake, the fetch and loader request/response
//   channels, and the SRAM macro bus of imem_arbiter.
//   slave  : arbiter view (requests/rdata in, grants/responses/mem_* out)
//   master : environment view (CPU fetch, loader and SRAM macro side)
// Ports (signals):
//   boot_done_i/booted_o           boot handshake
//   fetch_* / load_*               requester channels
//   mem_* / mem_rdata_i            SRAM macro, 1-cycle read latency
// ---------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              boot_done_i;
    logic              booted_o;

    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic [31:0]       fetch_rdata_o;
    logic              fetch_err_o;

    logic              load_req_i;
    logic              load_we_i;
    logic [31:0]       load_addr_i;
    logic [3:0]        load_be_i;
    logic [31:0]       load_wdata_i;
    logic              load_gnt_o;
    logic              load_rvalid_o;
    logic [31:0]       load_rdata_o;
    logic              load_err_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  boot_done_i, fetch_req_i, fetch_addr_i,
               load_req_i, load_we_i, load_addr_i, load_be_i, load_wdata_i,
               mem_rdata_i,
        output booted_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
               load_gnt_o, load_rvalid_o, load_rdata_o, load_err_o,
               mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output boot_done_i, fetch_req_i, fetch_addr_i,
               load_req_i, load_we_i, load_addr_i, load_be_i, load_wdata_i,
               mem_rdata_i,
        input  booted_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
               load_gnt_o, load_rvalid_o, load_rdata_o, load_err_o,
               mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//   Single-port access controller for the instruction SRAM, shared by CPU
//   fetch and the program loader. Fetch is held off in BOOT until the loader
//   pulses boot_done; in RUN the loader has priority, but fetch wins once it
//   has been denied STARVE_LIMIT consecutive cycles. Grants are combinational;
//   read responses come back one cycle after the grant, routed to the owner.
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  asynchronous active-high reset
//   bus    imem_arbiter_if.slave: boot handshake, fetch/load channels, SRAM
// Optional feature (macro IMEM_ARB_ERR_EN): out-of-range addresses and
//   misaligned fetches are granted but not forwarded to the SRAM; reads
//   return err=1/rdata=0, writes pulse load_err_o. Without the macro the
//   address is simply truncated and the error outputs stay 0.
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {BOOT, RUN} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rerr_q, rerr_d;   // outstanding read is an errored access
    logic          werr_q, werr_d;   // errored write: one-cycle load_err pulse
    logic          fetch_bad, load_bad;

`ifdef IMEM_ARB_ERR_EN
    assign fetch_bad = (bus.fetch_addr_i[31:ADDR_W] != '0) || (bus.fetch_addr_i[1:0] != 2'b00);
    assign load_bad  = (bus.load_addr_i[31:ADDR_W] != '0);
    logic unused_load_lo;
    assign unused_load_lo = ^bus.load_addr_i[1:0];
`else
    assign fetch_bad = 1'b0;
    assign load_bad  = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.fetch_addr_i[31:ADDR_W], bus.fetch_addr_i[1:0],
                                bus.load_addr_i[31:ADDR_W], bus.load_addr_i[1:0]};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= BOOT;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            rerr_q   <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            rerr_q   <= rerr_d;
            werr_q   <= werr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = OWN_NONE;
        starve_d        = '0;
        rerr_d          = 1'b0;
        werr_d          = 1'b0;
        bus.fetch_gnt_o = 1'b0;
        bus.load_gnt_o  = 1'b0;
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;

        if (state_q == BOOT) begin
            if (bus.boot_done_i) state_d = RUN;
            bus.load_gnt_o = bus.load_req_i;
        end else begin
            if (bus.fetch_req_i && bus.load_req_i) begin
                if (starve_q == SW'(STARVE_LIMIT)) bus.fetch_gnt_o = 1'b1;
                else                               bus.load_gnt_o  = 1'b1;
            end else begin
                bus.fetch_gnt_o = bus.fetch_req_i;
                bus.load_gnt_o  = bus.load_req_i;
            end
            // Count consecutive denied cycles; any grant or idle cycle clears it.
            if (bus.fetch_req_i && !bus.fetch_gnt_o)
                starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        end

        if (bus.fetch_gnt_o) begin
            bus.mem_en_o   = !fetch_bad;
            bus.mem_addr_o = bus.fetch_addr_i[ADDR_W-1:2];
            owner_d        = OWN_FETCH;
            rerr_d         = fetch_bad;
        end else if (bus.load_gnt_o) begin
            bus.mem_en_o    = !load_bad;
            bus.mem_we_o    = bus.load_we_i && !load_bad;
            bus.mem_be_o    = (bus.load_we_i && !load_bad) ? bus.load_be_i : 4'h0;
            bus.mem_addr_o  = bus.load_addr_i[ADDR_W-1:2];
            bus.mem_wdata_o = bus.load_wdata_i;
            if (bus.load_we_i) begin
                werr_d = load_bad;
            end else begin
                owner_d = OWN_LOAD;
                rerr_d  = load_bad;
            end
        end
    end

    assign bus.booted_o       = (state_q == RUN);
    assign bus.fetch_rvalid_o = (owner_q == OWN_FETCH);
    assign bus.fetch_rdata_o  = (owner_q == OWN_FETCH && !rerr_q) ? bus.mem_rdata_i : 32'h0;
    assign bus.fetch_err_o    = (owner_q == OWN_FETCH) && rerr_q;
    assign bus.load_rvalid_o  = (owner_q == OWN_LOAD);
    assign bus.load_rdata_o   = (owner_q == OWN_LOAD && !rerr_q) ? bus.mem_rdata_i : 32'h0;
    assign bus.load_err_o     = ((owner_q == OWN_LOAD) && rerr_q) || werr_q;
endmodule
